// File: rtl/tristate_8bit_pkg.sv
// tristate_8bit_pkg: shared widths and the released-bus pattern for the tristate bus driver
package tristate_8bit_pkg;
    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_CNT_W = 16;
    localparam logic [DEFAULT_WIDTH-1:0] Z_BUS = {DEFAULT_WIDTH{1'bz}};
endpackage

// File: rtl/tristate_monitor.sv
// tristate_monitor: registers the drive enable, flags its edges and counts drive cycles
module tristate_monitor
    import tristate_8bit_pkg::*;
#(
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             T,
    output logic             oe_q,
    output logic             oe_rise,
    output logic             oe_fall,
    output logic [CNT_W-1:0] drive_cnt
);
    // Sample T each edge; the counter sticks at all-ones instead of wrapping
    always_ff @(posedge clk) begin
        if (reset) begin
            oe_q      <= 1'b0;
            oe_rise   <= 1'b0;
            oe_fall   <= 1'b0;
            drive_cnt <= '0;
        end else begin
            oe_q    <= T;
            oe_rise <= T & ~oe_q;
            oe_fall <= ~T & oe_q;
            if (T && drive_cnt != '1)
                drive_cnt <= drive_cnt + CNT_W'(1);
        end
    end
endmodule

// File: rtl/tristate_8bit.sv
// tristate_8bit: drives a shared bus from I while T=1, releases it otherwise, with a debug monitor
module tristate_8bit
    import tristate_8bit_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             T,
    input  logic [WIDTH-1:0] I,
    output tri   [WIDTH-1:0] O,
    output logic             oe_q,
    output logic             oe_rise,
    output logic             oe_fall,
    output logic [CNT_W-1:0] drive_cnt
);
    // Purely combinational and independent of reset: the bus follows T and I at all times
    assign O = T ? I : {WIDTH{1'bz}};

    tristate_monitor #(.CNT_W(CNT_W)) monitor (
        .clk(clk),
        .reset(reset),
        .T(T),
        .oe_q(oe_q),
        .oe_rise(oe_rise),
        .oe_fall(oe_fall),
        .drive_cnt(drive_cnt)
    );
endmodule

// File: tb/tb_tristate_8bit.sv
// tb_tristate_8bit: random and directed checks of the bus driver and monitor against a behavioural model
module tb_tristate_8bit;
    import tristate_8bit_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic T = 1'b0;
    logic [7:0] I = 8'h00;
    logic helperEn = 1'b1;
    logic [7:0] helperVal = 8'h00;
    tri [7:0] bus;
    tri [7:0] bus4;
    logic oeQ, oeRise, oeFall, oeQ4, oeRise4, oeFall4;
    logic [15:0] driveCnt;
    logic [3:0] driveCnt4;

    int vectors = 0;
    int miscompares = 0;
    bit checkOn = 0;

    int mQ = 0, mRise = 0, mFall = 0, mCnt = 0, mCnt4 = 0;

    always #5 clk = ~clk;

    // A second driver that only drives while the DUT is meant to be released
    assign bus  = helperEn ? helperVal : Z_BUS;
    assign bus4 = helperEn ? helperVal : Z_BUS;

    tristate_8bit dut (
        .clk(clk), .reset(reset), .T(T), .I(I), .O(bus),
        .oe_q(oeQ), .oe_rise(oeRise), .oe_fall(oeFall), .drive_cnt(driveCnt)
    );

    tristate_8bit #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .T(T), .I(I), .O(bus4),
        .oe_q(oeQ4), .oe_rise(oeRise4), .oe_fall(oeFall4), .drive_cnt(driveCnt4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic setIn(input logic t, input logic [7:0] i);
        T = t;
        I = i;
        helperEn = ~t;
    endtask

    task automatic checkBus(input string name);
        #1;
        check({name, " O"}, {24'h0, bus}, {24'h0, T ? I : helperVal});
        check({name, " O4"}, {24'h0, bus4}, {24'h0, T ? I : helperVal});
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Model: the monitor remembers the last sampled T and counts sampled highs, capped at the maximum
    always @(posedge clk) begin
        int t;
        t = (T === 1'b1) ? 1 : 0;
        if (reset === 1'b1) begin
            mQ = 0; mRise = 0; mFall = 0; mCnt = 0; mCnt4 = 0;
        end else begin
            mRise = (t == 1 && mQ == 0) ? 1 : 0;
            mFall = (t == 0 && mQ == 1) ? 1 : 0;
            mQ = t;
            mCnt = (mCnt + t > 65535) ? 65535 : mCnt + t;
            mCnt4 = (mCnt4 + t > 15) ? 15 : mCnt4 + t;
        end
        #1;
        if (checkOn) begin
            check("oe_q", {31'h0, oeQ}, mQ);
            check("oe_rise", {31'h0, oeRise}, mRise);
            check("oe_fall", {31'h0, oeFall}, mFall);
            check("drive_cnt", {16'h0, driveCnt}, mCnt);
            check("oe_q4", {31'h0, oeQ4}, mQ);
            check("drive_cnt4", {28'h0, driveCnt4}, mCnt4);
        end
    end

    initial begin
        setIn(1'b0, 8'h00);
        helperVal = 8'h00;
        checkBus("released zero");
        helperVal = 8'h5A;
        checkBus("released 5A");
        cyc(2);
        reset = 1'b0;
        checkOn = 1;
        check("reset oe_q", {31'h0, oeQ}, 0);
        check("reset drive_cnt", {16'h0, driveCnt}, 0);

        setIn(1'b1, 8'hA5);
        #1 check("drive A5", {24'h0, bus}, 32'hA5);
        cyc(1);
        check("first rise", {31'h0, oeRise}, 1);
        check("first oe_q", {31'h0, oeQ}, 1);
        check("cnt after 1", {16'h0, driveCnt}, 1);
        cyc(1);
        check("rise one cycle", {31'h0, oeRise}, 0);
        check("cnt after 2", {16'h0, driveCnt}, 2);

        I = 8'hFF;
        #1 check("drive FF", {24'h0, bus}, 32'hFF);
        cyc(3);
        check("cnt after 5", {16'h0, driveCnt}, 5);

        helperVal = 8'h00;
        setIn(1'b0, 8'hFF);
        #1 check("release after FF", {24'h0, bus}, 32'h00);
        cyc(1);
        check("fall", {31'h0, oeFall}, 1);
        check("cnt hold", {16'h0, driveCnt}, 5);
        cyc(1);
        check("fall one cycle", {31'h0, oeFall}, 0);

        setIn(1'b1, 8'h3C);
        cyc(2);
        reset = 1'b1;
        #1 check("drive during reset", {24'h0, bus}, 32'h3C);
        cyc(1);
        check("reset mid-drive O", {24'h0, bus}, 32'h3C);
        check("reset mid-drive oe_q", {31'h0, oeQ}, 0);
        check("reset mid-drive cnt", {16'h0, driveCnt}, 0);
        reset = 1'b0;
        cyc(1);
        check("rise after reset", {31'h0, oeRise}, 1);
        check("cnt after reset", {16'h0, driveCnt}, 1);

        cyc(20);
        check("cnt4 saturated", {28'h0, driveCnt4}, 32'hF);
        check("cnt16 running", {16'h0, driveCnt}, 21);

        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 24) == 0);
            helperVal = 8'($urandom);
            setIn($urandom_range(0, 3) != 0, 8'($urandom));
            checkBus("random");
            #1;
            if (T) begin
                I = 8'($urandom);
                checkBus("random I change");
            end
            if ($urandom_range(0, 4) == 0) begin
                setIn(~T, I);
                checkBus("glitch");
                setIn(~T, I);
                checkBus("glitch back");
            end
            cyc(1);
        end

        checkOn = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
